imm_gen_skid: RTL and testbench

Parametrised immediate generator for the execute stage. It handles all RV32I immediate formats (I, S, B, U, J) and the CSR zero-extended uimm, sign- or zero-extends the result to XLEN, and returns it through a valid/ready handshake. A 2-entry skid buffer breaks the ready path between decode and execute, so back-pressure never combinationally reaches the decoder.

---
 rtl/imm_gen_skid_pkg.sv | 16 +
 rtl/imm_gen_skid_imm_build.sv | 41 ++++
 rtl/imm_gen_skid.sv | 80 ++++++++
 tb/tb_imm_gen_skid.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_skid_pkg.sv
// Shared constants for the immediate generator: format codes, default XLEN, booleans.
package imm_gen_skid_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_Z = 3'd5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/imm_gen_skid_imm_build.sv
// Combinational RV32I immediate decode (I/S/B/U/J sign-extended, Z zero-extended) to XLEN.
module imm_build
    import imm_gen_skid_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic [31:0] imm32;
    logic        unused_opc;

    assign unused_opc = ^instr[6:0];

    // imm32 is already sign-extended to 32 bits, so widening only replicates bit 31.
    always_comb begin
        imm32 = '0;
        err   = FALSE;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_Z: imm32 = {27'b0, instr[19:15]};
            default: err = TRUE;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign imm = {{32{imm32[31]}}, imm32};
        end else begin : g_x32
            assign imm = imm32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_skid.sv
// Immediate generator with a 2-entry output/skid buffer; in_ready depends only on flops.
module imm_gen_skid
    import imm_gen_skid_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_skid: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             err;
        logic [TAG_W-1:0] tag;
    } item_t;

    item_t nw, or_q, sk_q;
    logic  or_vld, sk_vld;
    logic  acc, or_free;

    imm_build #(.XLEN(XLEN)) u_build (
        .instr (in_instr),
        .fmt   (in_fmt),
        .imm   (nw.imm),
        .err   (nw.err)
    );
    assign nw.tag = in_tag;

    assign in_ready = !sk_vld;
    assign acc      = in_valid && in_ready;
    assign or_free  = !or_vld || out_ready;

    // SK is only refilled while OR is stalled, and always empties into OR first,
    // so FIFO order holds and in_ready can never be high while SK is occupied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            or_vld <= FALSE;
            sk_vld <= FALSE;
            or_q   <= '0;
            sk_q   <= '0;
        end else if (or_free) begin
            if (sk_vld) begin
                or_q   <= sk_q;
                or_vld <= TRUE;
                sk_vld <= FALSE;
            end else if (acc) begin
                or_q   <= nw;
                or_vld <= TRUE;
            end else begin
                or_vld <= FALSE;
            end
        end else if (acc) begin
            sk_q   <= nw;
            sk_vld <= TRUE;
        end
    end

    assign out_valid = or_vld;
    assign out_imm   = or_q.imm;
    assign out_err   = or_q.err;
    assign out_tag   = or_q.tag;

endmodule

// File: tb/tb_imm_gen_skid.sv
// Directed bench for imm_gen_skid: format decode at XLEN 32/64, back-pressure, throughput, reset.
module tb_imm_gen_skid;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;

    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    int nchk = 0;
    int nerr = 0;
    int ndrain;
    logic [4:0] send_q[$];
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    imm_gen_skid #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_err(out_err), .out_tag(out_tag)
    );

    imm_gen_skid #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_err(out_err64), .out_tag(out_tag64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the streaming model: offer the queue head (I-format, imm == tag),
    // record accepts into the expected FIFO and check every drained item against it.
    task automatic tick();
        logic       a, d;
        logic [4:0] t;
        logic [31:0] im;
        in_valid = (send_q.size() > 0);
        in_tag   = in_valid ? send_q[0] : 5'd0;
        in_fmt   = 3'd0;
        in_instr = {7'd0, in_tag, 20'h00013};
        a  = in_valid && in_ready;
        d  = out_valid && out_ready;
        t  = out_tag;
        im = out_imm;
        @(posedge clk); #1;
        if (d) begin
            ndrain++;
            if (exp_q.size() == 0) chk("dup_item", {59'd0, t}, 64'hdead);
            else begin
                chk("order_tag", {59'd0, t}, {59'd0, exp_q[0]});
                chk("order_imm", {32'd0, im}, {59'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
        if (a) exp_q.push_back(send_q.pop_front());
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [4:0]  tag;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        eerr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h800000EF, 3'd4, 5'h03, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[1] = '{32'hFFF00093, 3'd0, 5'h04, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[2] = '{32'h7E000FA3, 3'd1, 5'h05, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[3] = '{32'hFE000EE3, 3'd2, 5'h06, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[4] = '{32'h800002B7, 3'd3, 5'h07, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[5] = '{32'h000FD073, 3'd5, 5'h08, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 3'd6, 5'h1A, 32'h00000000, 64'h0000000000000000, 1'b1};
        vecs[7] = '{32'h12345678, 3'd7, 5'h1B, 32'h00000000, 64'h0000000000000000, 1'b1};

        reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_fmt = '0; in_tag = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_imm",   {32'd0, out_imm},   64'd0);
        chk("rst_out_err",   {63'd0, out_err},   64'd0);
        chk("rst_out_tag",   {59'd0, out_tag},   64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed format vectors, one item in flight at a time
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_fmt = vecs[i].fmt; in_tag = vecs[i].tag;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("vec%0d_imm32", i), {32'd0, out_imm}, {32'd0, vecs[i].e32});
            chk($sformatf("vec%0d_imm64", i), out_imm64, vecs[i].e64);
            chk($sformatf("vec%0d_err", i), {63'd0, out_err}, {63'd0, vecs[i].eerr});
            chk($sformatf("vec%0d_err64", i), {63'd0, out_err64}, {63'd0, vecs[i].eerr});
            chk($sformatf("vec%0d_tag", i), {59'd0, out_tag}, {59'd0, vecs[i].tag});
        end
        @(posedge clk); #1;
        chk("idle_after_vecs", {63'd0, out_valid}, 64'd0);

        // Back-pressure: 4 items, consumer stalls after the first lands in OR
        ndrain = 0;
        send_q = '{5'd1, 5'd2, 5'd3, 5'd4};
        tick();
        out_ready = 1'b0;
        tick();
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_or_valid", {63'd0, out_valid}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_or_tag_stable", {59'd0, out_tag}, 64'd1);
            chk("bp_or_imm_stable", {32'd0, out_imm}, 64'd1);
            chk("bp_in_ready_held", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (send_q.size() == 0 && exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        chk("bp_drained", {32'd0, ndrain}, 64'd4);
        chk("bp_leftover", {32'd0, exp_q.size() + send_q.size()}, 64'd0);

        // Full throughput: 16 items back to back
        ndrain = 0;
        for (int k = 0; k < 16; k++) send_q.push_back(5'(k + 16));
        for (int k = 0; k < 17; k++) begin
            chk("tp_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
        end
        chk("tp_drained", {32'd0, ndrain}, 64'd16);
        chk("tp_idle", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset with both entries full
        out_ready = 1'b0;
        send_q = '{5'd7, 5'd8, 5'd9};
        tick();
        tick();
        chk("rm_full_valid", {63'd0, out_valid}, 64'd1);
        chk("rm_full_ready", {63'd0, in_ready}, 64'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rm_valid_now", {63'd0, out_valid}, 64'd0);
        chk("rm_ready_now", {63'd0, in_ready}, 64'd1);
        chk("rm_tag_now", {59'd0, out_tag}, 64'd0);
        send_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rm_no_stale", {63'd0, out_valid}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish before 50000");
        $fatal(1);
    end

endmodule
